// File: rtl/parity_stream_chk.sv
// -----------------------------------------------------------------------------
// parity_stream_chk
//   Streaming parity generator/checker with one register stage. Every accepted
//   beat is forwarded together with its beat parity. On the last beat of a frame
//   the frame parity over all data bits of the frame is also presented. In check
//   mode the received beat/frame parity bits are compared against the computed
//   ones, mismatches are flagged per beat and counted in a saturating counter.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   chk_mode                    0: generate, 1: check (taken with each beat)
//   in_valid/in_ready           input handshake (in_ready is combinational)
//   in_data, in_par, in_last    input beat, received beat parity, end of frame
//   in_fpar                     received frame parity (with in_last)
//   out_valid/out_ready         output handshake
//   out_data, out_par           registered beat and its computed parity
//   out_last, out_fpar          registered end of frame, computed frame parity
//   out_err                     beat or frame parity mismatch (check mode)
//   err_cnt, err_cnt_clr        saturating error-beat count and its sync clear
//
// States
//   IDLE     | no beat of the current frame accepted yet, acc = 0
//   IN_FRAME | at least one non-last beat accepted, acc = XOR of its data bits
// -----------------------------------------------------------------------------
module parity_stream_chk #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chk_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_last,
    input  logic              in_fpar,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par,
    output logic              out_last,
    output logic              out_fpar,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              err_cnt_clr
);

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    localparam logic ODD_B = (ODD != 0);

    state_t             state_q;
    logic               acc_q;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic               out_par_q;
    logic               out_last_q;
    logic               out_fpar_q;
    logic               out_err_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [CNT_W-1:0]   err_cnt_d;

    logic accept;
    logic out_hs;
    logic data_x;
    logic beat_par;
    logic frame_par;
    logic beat_err;

    // No skid buffer: a new beat is taken only when the output register is free
    // or is being drained in the same cycle.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;

    assign data_x    = ^in_data;
    assign beat_par  = data_x ^ ODD_B;
    // acc_q is zero in IDLE, so this also covers single-beat frames.
    assign frame_par = acc_q ^ data_x ^ ODD_B;
    assign beat_err  = chk_mode &&
                       ((in_par != beat_par) || (in_last && (in_fpar != frame_par)));

    // Clear has priority over a concurrent counted error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (out_hs && out_err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_fpar_q  <= 1'b0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data;
                out_par_q   <= beat_par;
                out_last_q  <= in_last;
                out_fpar_q  <= in_last ? frame_par : 1'b0;
                out_err_q   <= beat_err;
                case (state_q)
                    IDLE: begin
                        if (in_last) begin
                            state_q <= IDLE;
                            acc_q   <= 1'b0;
                        end else begin
                            state_q <= IN_FRAME;
                            acc_q   <= data_x;
                        end
                    end
                    IN_FRAME: begin
                        if (in_last) begin
                            state_q <= IDLE;
                            acc_q   <= 1'b0;
                        end else begin
                            state_q <= IN_FRAME;
                            acc_q   <= acc_q ^ data_x;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        acc_q   <= 1'b0;
                    end
                endcase
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_par   = out_par_q;
    assign out_last  = out_last_q;
    assign out_fpar  = out_fpar_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_stream_chk.sv
// -----------------------------------------------------------------------------
// tb_parity_stream_chk
//   Two instances share one stimulus stream: u_a (DATA_W=8, even, CNT_W=8) and
//   u_b (DATA_W=8, odd, CNT_W=2). Expected beats are queued on acceptance and
//   popped by an independent monitor on each output handshake.
// -----------------------------------------------------------------------------
module tb_parity_stream_chk;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chk_mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_par = 1'b0;
    logic       in_last = 1'b0;
    logic       in_fpar = 1'b0;
    logic       out_ready = 1'b0;
    logic       err_cnt_clr = 1'b0;

    logic       a_in_ready, a_out_valid, a_out_par, a_out_last, a_out_fpar, a_out_err;
    logic [7:0] a_out_data;
    logic [7:0] a_err_cnt;
    logic       b_in_ready, b_out_valid, b_out_par, b_out_last, b_out_fpar, b_out_err;
    logic [7:0] b_out_data;
    logic [1:0] b_err_cnt;

    always #5 clk = ~clk;

    parity_stream_chk #(.DATA_W(8), .ODD(0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .chk_mode(chk_mode),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .in_par(in_par), .in_last(in_last), .in_fpar(in_fpar),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_par(a_out_par), .out_last(a_out_last), .out_fpar(a_out_fpar),
        .out_err(a_out_err), .err_cnt(a_err_cnt), .err_cnt_clr(err_cnt_clr)
    );

    parity_stream_chk #(.DATA_W(8), .ODD(1), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .chk_mode(chk_mode),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .in_par(in_par), .in_last(in_last), .in_fpar(in_fpar),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_par(b_out_par), .out_last(b_out_last), .out_fpar(b_out_fpar),
        .out_err(b_out_err), .err_cnt(b_err_cnt), .err_cnt_clr(err_cnt_clr)
    );

    typedef struct {
        logic [7:0] d;
        logic       p0, p1, l, f0, f1, e0, e1;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   facc = 1'b0;     // parity of all data bits seen so far in the frame
    int   cnt_a = 0;
    int   cnt_b = 0;
    bit   rdy_random = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: parity rules computed from bit counts.
    task automatic model_push(input logic [7:0] d, input logic par, input logic last,
                              input logic fpar, input logic chk_m);
        exp_t e;
        bit   ones, fr;
        ones = ($countones(d) % 2) == 1;
        fr   = facc ^ ones;
        e.d  = d;
        e.l  = last;
        e.p0 = ones;
        e.p1 = !ones;
        e.f0 = last ? fr : 1'b0;
        e.f1 = last ? !fr : 1'b0;
        e.e0 = chk_m && ((par != e.p0) || (last && (fpar != fr)));
        e.e1 = chk_m && ((par != e.p1) || (last && (fpar != !fr)));
        facc = last ? 1'b0 : fr;
        q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input logic [7:0] d, input logic par, input logic last,
                        input logic fpar, input logic chk_m);
        int  waited;
        bit  done;
        in_valid = 1'b1;
        in_data  = d;
        in_par   = par;
        in_last  = last;
        in_fpar  = fpar;
        chk_mode = chk_m;
        waited   = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (a_in_ready) begin
                model_push(d, par, last, fpar, chk_m);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 100) begin
                    chk("accept_timeout", 0, 1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    always @(posedge clk) begin
        if (rdy_random) begin
            #1;
            if (rdy_random) out_ready = ($urandom % 4) != 0;
        end
    end

    // Monitor: compares the presented beat with the queue head every cycle,
    // which also covers stability while stalled; pops on handshake.
    always @(negedge clk) begin
        exp_t e;
        bit   hs, ea, eb;
        if (rst_n) begin
            hs = 1'b0; ea = 1'b0; eb = 1'b0;
            chk("in_ready", a_in_ready, !a_out_valid || out_ready);
            chk("in_ready_b", b_in_ready, a_in_ready);
            chk("out_valid_b", b_out_valid, a_out_valid);
            chk("err_cnt_a", a_err_cnt, cnt_a);
            chk("err_cnt_b", b_err_cnt, cnt_b);
            if (a_out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = q[0];
                    chk("data_a", a_out_data, e.d);
                    chk("par_a", a_out_par, e.p0);
                    chk("last_a", a_out_last, e.l);
                    chk("fpar_a", a_out_fpar, e.f0);
                    chk("err_a", a_out_err, e.e0);
                    chk("data_b", b_out_data, e.d);
                    chk("par_b", b_out_par, e.p1);
                    chk("last_b", b_out_last, e.l);
                    chk("fpar_b", b_out_fpar, e.f1);
                    chk("err_b", b_out_err, e.e1);
                    if (out_ready) begin
                        void'(q.pop_front());
                        hs = 1'b1; ea = e.e0; eb = e.e1;
                    end
                end
            end
            if (err_cnt_clr) begin
                cnt_a = 0;
                cnt_b = 0;
            end else begin
                if (hs && ea && cnt_a < 255) cnt_a++;
                if (hs && eb && cnt_b < 3) cnt_b++;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, {a_out_valid, b_out_valid}, 0);
        chk({tag, "_data"}, {a_out_data, b_out_data}, 0);
        chk({tag, "_par"}, {a_out_par, b_out_par, a_out_last, b_out_last}, 0);
        chk({tag, "_fpar"}, {a_out_fpar, b_out_fpar, a_out_err, b_out_err}, 0);
        chk({tag, "_cnt"}, {a_err_cnt, b_err_cnt}, 0);
        chk({tag, "_in_ready"}, {a_in_ready, b_in_ready}, 2'b11);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        #12;
        check_idle_outputs("reset_held");
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle_outputs("reset_released");

        // Beat parity, even and odd instances.
        send(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("par_A5_even", a_out_par, 1'b0);
        send(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("par_01_even", a_out_par, 1'b1);
        chk("par_01_odd", b_out_par, 1'b0);

        // Three-beat frame: 1+2+3 set bits = 6, so even frame parity is 0.
        send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fpar_beat1", a_out_fpar, 1'b0);
        send(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fpar_beat2", a_out_fpar, 1'b0);
        send(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fpar_beat3", a_out_fpar, 1'b0);
        chk("fpar_beat3_odd", b_out_fpar, 1'b1);
        send(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fpar_FF", a_out_fpar, 1'b0);

        // Check mode: beat error, clean beat, frame error.
        send(8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("chk_bad_par", a_out_err, 1'b1);
        send(8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("chk_good", a_out_err, 1'b0);
        send(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("chk_bad_fpar", a_out_err, 1'b1);
        wait_drain("drain_chk");
        chk("cnt_after_chk", a_err_cnt, 2);

        // Backpressure: beat held for 3 cycles, next beat must wait.
        out_ready = 1'b0;
        send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        fork
            send(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", a_in_ready, 1'b0);
                    chk("stall_data", a_out_data, 8'h5A);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("drain_bp");

        // Saturation of the 2-bit counter, then clear against an error handshake.
        repeat (5) send(8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_drain("drain_sat");
        chk("cnt_b_saturated", b_err_cnt, 3);
        out_ready = 1'b0;
        send(8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
        out_ready   = 1'b1;
        err_cnt_clr = 1'b1;
        @(posedge clk);
        #1 err_cnt_clr = 1'b0;
        chk("clr_wins_a", a_err_cnt, 0);
        chk("clr_wins_b", b_err_cnt, 0);

        // Randomised traffic with random stalls and occasional clears.
        rdy_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            err_cnt_clr = ($urandom % 20) == 0;
            send(8'($urandom), 1'($urandom), ($urandom % 4) == 0,
                 1'($urandom), 1'($urandom));
            err_cnt_clr = 1'b0;
        end
        rdy_random = 1'b0;
        #1 out_ready = 1'b1;
        wait_drain("drain_random");

        // Reset mid-frame with a pending output beat.
        send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", a_out_valid, 1'b1);
        rst_n = 1'b0;
        q.delete();
        facc  = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        #1;
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_reset_fpar", a_out_fpar, 1'b1);
        chk("post_reset_fpar_odd", b_out_fpar, 1'b0);
        wait_drain("drain_final");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
